// File: rtl/rtc_uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rtc_uart_pkg : shared state encoding, ASCII constants, frame lengths   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package rtc_uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_SEND      = ST_SEND,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_GAP       = ST_GAP
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ERR  = 8'h3F;

    localparam int unsigned FRAME_LEN_SHORT = 8;
    localparam int unsigned FRAME_LEN_CRLF  = 10;

endpackage
`default_nettype wire

// File: rtl/rtc_bcd2ascii.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rtc_bcd2ascii : one BCD digit to ASCII, invalid digits become '?'      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module rtc_bcd2ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    import rtc_uart_pkg::*;

    always_comb begin
        if (nibble <= 4'd9) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_ERR;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_time_tx_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rtc_time_tx_seq : sends a snapshot of the RTC time as "HH:MM:SS\r\n"   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module rtc_time_tx_seq #(
    parameter logic [7:0]  SEP_CHAR    = 8'h3A,
    parameter bit          APPEND_CRLF = 1'b1,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic [7:0] hour_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       tx_done,
    output logic       send_en,
    output logic [7:0] data,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);
    import rtc_uart_pkg::*;

    localparam logic [3:0] c_last_idx = APPEND_CRLF ? 4'(FRAME_LEN_CRLF - 1)
                                                    : 4'(FRAME_LEN_SHORT - 1);
    localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_idx;
    logic [23:0] r_snap;
    logic [7:0]  r_data;
    logic [7:0]  r_gap_cnt;
    logic        r_frame_done;
    logic        r_overrun;
    logic [3:0]  w_nibble;
    logic [7:0]  w_ascii;
    logic [7:0]  w_byte;
    logic        w_accept;
    logic        w_last_done;

    // A trigger in the frame_done cycle counts as arriving during the frame.
    assign w_accept    = (r_state == S_IDLE) && trigger && !r_frame_done;
    assign w_last_done = (r_state == S_WAIT_DONE) && tx_done && (r_idx == c_last_idx);

    always_comb begin
        case (r_idx)
            4'd0:    w_nibble = r_snap[23:20];
            4'd1:    w_nibble = r_snap[19:16];
            4'd3:    w_nibble = r_snap[15:12];
            4'd4:    w_nibble = r_snap[11:8];
            4'd6:    w_nibble = r_snap[7:4];
            4'd7:    w_nibble = r_snap[3:0];
            default: w_nibble = 4'd0;
        endcase
    end

    rtc_bcd2ascii u_bcd2ascii (
        .nibble (w_nibble),
        .ascii  (w_ascii)
    );

    always_comb begin
        case (r_idx)
            4'd2, 4'd5: w_byte = SEP_CHAR;
            4'd8:       w_byte = ASCII_CR;
            4'd9:       w_byte = ASCII_LF;
            default:    w_byte = w_ascii;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        send_en      = 1'b0;
        busy         = (r_state != S_IDLE);
        data         = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_SEND;
            end
            S_SEND: begin
                send_en      = 1'b1;
                data         = w_byte;
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    if (r_idx == c_last_idx) w_next_state = S_IDLE;
                    else if (GAP_CYCLES != 0) w_next_state = S_GAP;
                    else w_next_state = S_SEND;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_gap_last) w_next_state = S_SEND;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= 4'd0;
            r_snap       <= 24'd0;
            r_data       <= 8'h00;
            r_gap_cnt    <= 8'd0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_last_done;
            r_overrun    <= trigger && !w_accept;
            if (w_accept) begin
                r_snap <= {hour_bcd, min_bcd, sec_bcd};
                r_idx  <= 4'd0;
            end else if ((r_state == S_WAIT_DONE) && tx_done && (r_idx != c_last_idx)) begin
                r_idx <= r_idx + 4'd1;
            end
            if (r_state == S_SEND) r_data <= w_byte;
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 8'd1;
            else r_gap_cnt <= 8'd0;
        end
    end

    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_tx_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rtc_time_tx_seq : three configurations driven by shared stimulus    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_rtc_time_tx_seq;

    localparam int NDUT     = 3;
    localparam int TX_DELAY = 20;
    localparam int LOGSZ    = 512;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trigger = 1'b0;
    logic [7:0]      hour_bcd = 8'h00;
    logic [7:0]      min_bcd  = 8'h00;
    logic [7:0]      sec_bcd  = 8'h00;
    logic [NDUT-1:0] tx_done;
    logic [NDUT-1:0] send_en, busy, frame_done, overrun;
    logic [7:0]      data_v [NDUT];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // dut0: defaults; dut1: no CRLF, no gap; dut2: CRLF, gap of 3
    rtc_time_tx_seq #(.SEP_CHAR(8'h3A), .APPEND_CRLF(1'b1), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .trigger(trigger), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .tx_done(tx_done[0]), .send_en(send_en[0]), .data(data_v[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .overrun(overrun[0]));
    rtc_time_tx_seq #(.SEP_CHAR(8'h3A), .APPEND_CRLF(1'b0), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .trigger(trigger), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .tx_done(tx_done[1]), .send_en(send_en[1]), .data(data_v[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .overrun(overrun[1]));
    rtc_time_tx_seq #(.SEP_CHAR(8'h3A), .APPEND_CRLF(1'b1), .GAP_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .trigger(trigger), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
        .sec_bcd(sec_bcd), .tx_done(tx_done[2]), .send_en(send_en[2]), .data(data_v[2]),
        .busy(busy[2]), .frame_done(frame_done[2]), .overrun(overrun[2]));

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 0 : 3;
    endfunction

    function automatic int len_of(input int k);
        return (k == 1) ? 8 : 10;
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : 8'h3F;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %0h, want %0h", name, k, cyc, act, exp);
        end
    endtask

    // Frame-level model: expected event cycles plus the byte list of the frame
    logic [7:0] frm [NDUT][10];
    int         pos [NDUT];
    int         exp_send [NDUT];
    int         exp_fd [NDUT];
    int         exp_ov [NDUT];
    bit         m_busy [NDUT];
    bit         m_wait [NDUT];
    logic [7:0] m_data [NDUT];
    bit         send_now;
    bit         busy_now;

    // Observation logs used by the directed literal checks
    int         sent_cnt [NDUT];
    int         fd_cnt [NDUT];
    int         ov_cnt [NDUT];
    logic [7:0] sent_log [NDUT][LOGSZ];
    int         last_txd [NDUT];
    int         gap_meas [NDUT];
    int         first_lat [NDUT];
    bit         prev_busy [NDUT];
    int         last_trig = 0;

    task automatic model_reset(input int k);
        pos[k]      = 0;
        exp_send[k] = -1;
        exp_fd[k]   = -1;
        exp_ov[k]   = -1;
        m_busy[k]   = 1'b0;
        m_wait[k]   = 1'b0;
        m_data[k]   = 8'h00;
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            model_reset(k);
            sent_cnt[k] = 0; fd_cnt[k] = 0; ov_cnt[k] = 0;
            last_txd[k] = 0; gap_meas[k] = -1; first_lat[k] = -1; prev_busy[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NDUT; k++) begin
                if (rst) model_reset(k);
                busy_now = m_busy[k];
                send_now = (cyc == exp_send[k]);
                if (send_now) m_data[k] = frm[k][pos[k]];
                chk("send_en", k, 32'(send_en[k]), 32'(send_now));
                chk("data", k, 32'(data_v[k]), 32'(m_data[k]));
                chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
                chk("frame_done", k, 32'(frame_done[k]), 32'(cyc == exp_fd[k]));
                chk("overrun", k, 32'(overrun[k]), 32'(cyc == exp_ov[k]));

                if (send_en[k]) begin
                    if (sent_cnt[k] < LOGSZ) sent_log[k][sent_cnt[k]] = data_v[k];
                    sent_cnt[k]++;
                    if (!prev_busy[k]) first_lat[k] = cyc - last_trig;
                    else gap_meas[k] = cyc - last_txd[k];
                end
                if (frame_done[k]) fd_cnt[k]++;
                if (overrun[k]) ov_cnt[k]++;
                if (tx_done[k]) last_txd[k] = cyc;
                prev_busy[k] = busy[k];

                if (!rst) begin
                    if (tx_done[k] && m_wait[k]) begin
                        m_wait[k] = 1'b0;
                        if (pos[k] == len_of(k) - 1) begin
                            exp_fd[k] = cyc + 1;
                            m_busy[k] = 1'b0;
                        end else begin
                            pos[k]++;
                            exp_send[k] = cyc + gap_of(k) + 1;
                        end
                    end
                    if (send_now) m_wait[k] = 1'b1;
                    if (trigger) begin
                        if (!busy_now && cyc != exp_fd[k]) begin
                            frm[k][0] = digit(hour_bcd[7:4]);
                            frm[k][1] = digit(hour_bcd[3:0]);
                            frm[k][2] = 8'h3A;
                            frm[k][3] = digit(min_bcd[7:4]);
                            frm[k][4] = digit(min_bcd[3:0]);
                            frm[k][5] = 8'h3A;
                            frm[k][6] = digit(sec_bcd[7:4]);
                            frm[k][7] = digit(sec_bcd[3:0]);
                            frm[k][8] = 8'h0D;
                            frm[k][9] = 8'h0A;
                            pos[k] = 0;
                            exp_send[k] = cyc + 1;
                            m_busy[k] = 1'b1;
                        end else begin
                            exp_ov[k] = cyc + 1;
                        end
                    end
                end
            end
            if (trigger) last_trig = cyc;
        end
    end

    // Byte transmitter stand-in: tx_done TX_DELAY cycles after each send_en
    int rsp_cnt [NDUT];
    initial begin
        tx_done = '0;
        for (int k = 0; k < NDUT; k++) rsp_cnt[k] = -1;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                tx_done[k] = 1'b0;
                if (rst) rsp_cnt[k] = -1;
                else if (send_en[k]) rsp_cnt[k] = TX_DELAY;
                else if (rsp_cnt[k] > 0) begin
                    rsp_cnt[k]--;
                    if (rsp_cnt[k] == 0) begin
                        tx_done[k] = 1'b1;
                        rsp_cnt[k] = -1;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy != '0 || frame_done != '0) && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", 0, 32'(n >= budget), 32'd0);
    endtask

    task automatic wait_sends(input int k, input int target, input int budget);
        int n;
        n = 0;
        while (sent_cnt[k] < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("send_timeout", k, 32'(n >= budget), 32'd0);
    endtask

    logic [7:0] exp1 [10];
    int b [NDUT];
    int f [NDUT];
    int o [NDUT];
    int n;

    task automatic snap_counts();
        for (int k = 0; k < NDUT; k++) begin
            b[k] = sent_cnt[k]; f[k] = fd_cnt[k]; o[k] = ov_cnt[k];
        end
    endtask

    initial begin
        exp1 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        tick(2);
        chk("reset_send_en", 0, 32'(send_en), 32'd0);
        chk("reset_busy", 0, 32'(busy), 32'd0);
        chk("reset_data", 0, 32'(data_v[0]), 32'd0);
        rst = 1'b0;
        tick(3);

        // Basic frame on all three configurations
        hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56;
        snap_counts();
        pulse_trigger();
        wait_idle(2000);
        for (int i = 0; i < 10; i++) chk("frame1_byte", 0, 32'(sent_log[0][b[0] + i]), 32'(exp1[i]));
        for (int i = 0; i < 8; i++) chk("frame1_byte", 1, 32'(sent_log[1][b[1] + i]), 32'(exp1[i]));
        chk("frame1_count", 0, 32'(sent_cnt[0] - b[0]), 32'd10);
        chk("frame1_count", 1, 32'(sent_cnt[1] - b[1]), 32'd8);
        chk("frame1_fd", 0, 32'(fd_cnt[0] - f[0]), 32'd1);
        chk("frame1_fd", 1, 32'(fd_cnt[1] - f[1]), 32'd1);
        chk("first_latency", 0, 32'(first_lat[0]), 32'd1);
        chk("first_latency", 2, 32'(first_lat[2]), 32'd1);
        chk("gap_interval", 0, 32'(gap_meas[0]), 32'd3);
        chk("gap_interval", 1, 32'(gap_meas[1]), 32'd1);
        chk("gap_interval", 2, 32'(gap_meas[2]), 32'd4);

        // Triggers mid-frame and in the frame_done cycle are dropped
        snap_counts();
        pulse_trigger();
        wait_sends(0, b[0] + 5, 1000);
        pulse_trigger();
        n = 0;
        while (!frame_done[0] && n < 1000) begin
            tick(1);
            n++;
        end
        chk("fd_timeout", 0, 32'(n >= 1000), 32'd0);
        pulse_trigger();
        tick(60);
        wait_idle(2000);
        chk("ovr_count", 0, 32'(ov_cnt[0] - o[0]), 32'd2);
        chk("ovr_frame_count", 0, 32'(sent_cnt[0] - b[0]), 32'd10);
        chk("ovr_fd", 0, 32'(fd_cnt[0] - f[0]), 32'd1);
        for (int i = 0; i < 10; i++) chk("ovr_byte", 0, 32'(sent_log[0][b[0] + i]), 32'(exp1[i]));

        // Invalid BCD digit and snapshot isolation
        hour_bcd = 8'h1A;
        snap_counts();
        pulse_trigger();
        tick(3);
        min_bcd = 8'h59;
        wait_idle(2000);
        chk("model_err_digit", 0, 32'(frm[0][1]), 32'h3F);
        chk("bcd_byte0", 0, 32'(sent_log[0][b[0]]), 32'h31);
        chk("bcd_byte1", 0, 32'(sent_log[0][b[0] + 1]), 32'h3F);
        chk("snap_min_tens", 0, 32'(sent_log[0][b[0] + 3]), 32'h33);
        chk("snap_min_units", 0, 32'(sent_log[0][b[0] + 4]), 32'h34);
        hour_bcd = 8'h12; min_bcd = 8'h34;

        // Reset while waiting for tx_done of byte 3
        snap_counts();
        pulse_trigger();
        wait_sends(0, b[0] + 4, 1000);
        tick(5);
        chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_send_en", 0, 32'(send_en[0]), 32'd0);
        chk("rst_data", 0, 32'(data_v[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_fd", 0, 32'(frame_done[0]), 32'd0);
        chk("rst_ovr", 0, 32'(overrun[0]), 32'd0);
        tick(3);
        rst = 1'b0;
        snap_counts();
        tick(50);
        for (int k = 0; k < NDUT; k++) chk("post_rst_quiet", k, 32'(sent_cnt[k] - b[k]), 32'd0);
        pulse_trigger();
        wait_idle(2000);
        chk("restart_count", 0, 32'(sent_cnt[0] - b[0]), 32'd10);
        chk("restart_byte0", 0, 32'(sent_log[0][b[0]]), 32'h31);
        chk("restart_byte9", 0, 32'(sent_log[0][b[0] + 9]), 32'h0A);
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtc_time_tx_seq.md
Name: rtc_time_tx_seq

Overview:
Message sequencer directly upstream of the UART byte transmitter in the rtc_uart path. On a trigger pulse it snapshots the RTC time (BCD hours/minutes/seconds) and sends the ASCII string "HH:MM:SS\r\n" one byte at a time. Each byte is handed over with a one-cycle send_en pulse, and the block waits for the transmitter's tx_done pulse before sending the next byte. It turns the RTC counter values into a periodic serial time report.

Parameters:
SEP_CHAR, 8'h3A, separator byte placed between HH/MM and MM/SS (default ':').
APPEND_CRLF, 1, 1 = append 8'h0D, 8'h0A (10-byte frame); 0 = 8-byte frame.
GAP_CYCLES, 2, idle clk cycles inserted after each tx_done before the next send_en (range 0..255).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
trigger  in  1  single-cycle request to start a frame (e.g. 1 Hz tick)
hour_bcd  in  8  BCD hours, tens in [7:4], units in [3:0]
min_bcd  in  8  BCD minutes
sec_bcd  in  8  BCD seconds
tx_done  in  1  single-cycle byte-complete pulse from the byte transmitter
send_en  out  1  single-cycle byte start pulse to the transmitter
data  out  8  byte to transmit; valid while send_en is high and held until the next load
busy  out  1  high whenever a frame is in progress
frame_done  out  1  single-cycle pulse when the final byte's tx_done is received
overrun  out  1  single-cycle pulse when a trigger is dropped because busy is high

Behaviour:
- Reset (asynchronous assert, immediate): send_en=0, data=8'h00, busy=0, frame_done=0, overrun=0, FSM=IDLE, byte index=0, snapshot=0. Reset mid-frame abandons the frame; no further send_en is issued.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
- IDLE:
  - On trigger=1, capture {hour_bcd, min_bcd, sec_bcd} into the snapshot register and set index=0.
  - In the next cycle, go to SEND.
  - Later changes on the time inputs do not affect the frame in flight.
- SEND (exactly one cycle):
  - send_en=1; data=byte[index].
  - Go to WAIT_DONE.
  - First send_en occurs exactly 1 cycle after trigger is sampled.
- WAIT_DONE:
  - Hold data. Wait for tx_done=1.
  - If index is the last byte (7 or 9): go to IDLE, pulse frame_done in that transition cycle, and drop busy in the same cycle.
  - Otherwise: increment index; go to GAP if GAP_CYCLES>0, else SEND.
- GAP:
  - Count GAP_CYCLES cycles, then go to SEND.
  - The next send_en occurs exactly GAP_CYCLES+1 cycles after the cycle in which tx_done was sampled high.
- Byte map:
  - 0: hour tens; 1: hour units; 2: SEP_CHAR
  - 3: min tens; 4: min units; 5: SEP_CHAR
  - 6: sec tens; 7: sec units
  - 8: 8'h0D; 9: 8'h0A
- Digit encoding: ASCII = 8'h30 + nibble for nibble 0..9. Nibble 10..15 (invalid BCD) is sent as 8'h3F ('?'); no other error action.
- busy = (FSM != IDLE).
- trigger while busy (including the cycle frame_done pulses): the trigger is ignored and overrun pulses 1 cycle later; the frame in flight is unaffected.
- tx_done outside WAIT_DONE is ignored (no state change, no error).
- No timeout: a missing tx_done leaves the block in WAIT_DONE until reset.
- trigger and tx_done in the same cycle in IDLE: the trigger is accepted and tx_done is ignored.

Decomposition:
- Shared package rtc_uart_pkg holds:
  - FSM state encoding (2-bit localparams).
  - ASCII constants: ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_ERR=8'h3F.
  - Frame lengths: 8 and 10.
- One combinational sub-module, rtc_bcd2ascii (4-bit nibble in, 8-bit ASCII out, with the invalid-digit mapping), instantiated once on the index-selected nibble.

Test Plan:
1. Reset, then trigger with hour=8'h12, min=8'h34, sec=8'h56, transmitter model returning tx_done 20 cycles after each send_en -> 10 send_en pulses carrying 31 32 3A 33 34 3A 35 36 0D 0A; one frame_done after the 10th tx_done; busy low afterwards.
2. GAP_CYCLES=0 versus GAP_CYCLES=3 -> the interval from tx_done to the next send_en is exactly 1 and 4 cycles respectively; first send_en is 1 cycle after trigger.
3. Trigger at byte 4 and again in the frame_done cycle -> two overrun pulses; frame bytes unchanged; no second frame.
4. hour=8'h1A; change min_bcd mid-frame -> bytes 31 3F; minutes sent from the snapshot, not the new value.
5. APPEND_CRLF=0 -> exactly 8 bytes; frame_done after the 8th tx_done.
6. Assert rst during WAIT_DONE at byte 3 -> all outputs 0 immediately; no send_en after release; a new trigger restarts at byte 0.
